mac_dot_sequencer: RTL and testbench
====================================

MAC_DOT_SEQUENCER -- requirements
Module: mac_dot_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the operand width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, meaning the MAC result width.
REQ-003 SHALL have parameter MAX_LEN, default 64, meaning the maximum vector length; ADDR_WIDTH = $clog2(MAX_LEN).
REQ-004 SHALL have parameter MAC_LATENCY, default 2, meaning the cycles from the last mac_valid to a settled mac_result.
REQ-005 SHALL provide `clk`, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL provide `reset_n`, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 SHALL provide `start`, input, 1 bit: a one-cycle request to run a dot product.
REQ-008 SHALL provide `len`, input, ADDR_WIDTH+1 bits: the vector length, sampled with `start`.
REQ-009 SHALL provide `busy`, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL provide `err`, output, 1 bit: a one-cycle pulse when `start` is rejected.
REQ-011 SHALL provide `rd_en`, output, 1 bit: the operand memory read strobe.
REQ-012 SHALL provide `rd_addr`, output, ADDR_WIDTH bits: the common read address for the A and B memories.
REQ-013 SHALL provide `a_data` and `b_data`, inputs, DATA_WIDTH bits each, signed: the memory read data, valid one cycle after `rd_en`.
REQ-014 SHALL provide `mac_multiplier` and `mac_multiplicand`, outputs, DATA_WIDTH bits each, signed: the operands driven to the MAC.
REQ-015 SHALL provide `mac_valid`, output, 1 bit: the MAC operand strobe.
REQ-016 SHALL provide `mac_clear`, output, 1 bit: the MAC accumulator clear.
REQ-017 SHALL provide `mac_result`, input, ACC_WIDTH bits, signed: the MAC accumulator output.
REQ-018 SHALL provide `out_data`, output, ACC_WIDTH bits, signed: the captured dot product.
REQ-019 SHALL provide `out_valid`, output, and `out_ready`, input, 1 bit each: the result handshake.

Function
REQ-020 SHALL implement states IDLE, CLEAR, ISSUE, DRAIN and DONE.
REQ-021 In IDLE, `start` with 1 <= len <= MAX_LEN SHALL latch `len` and move to CLEAR.
REQ-022 In IDLE, `start` with len = 0 or len > MAX_LEN SHALL pulse `err` the next cycle and stay in IDLE, with no `rd_en` and no `mac_clear`.
REQ-023 `start` outside IDLE SHALL be ignored, with no `err` and no effect on the current run.
REQ-024 CLEAR SHALL last exactly one cycle with `mac_clear` = 1, then move to ISSUE.
REQ-025 ISSUE SHALL assert `rd_en` for exactly `len` consecutive cycles, with `rd_addr` = 0, 1, ..., len-1, and no bubbles.
REQ-026 `mac_valid` SHALL be `rd_en` registered by one cycle, and `mac_multiplier`/`mac_multiplicand` SHALL equal `a_data`/`b_data` combinationally.
REQ-027 The cycle after the last `rd_en`, the block SHALL enter DRAIN and count MAC_LATENCY cycles after the final `mac_valid`.
REQ-028 At the end of DRAIN, the block SHALL register `mac_result` into `out_data`, set `out_valid` = 1 and enter DONE.
REQ-029 In DONE, `out_data` and `out_valid` SHALL hold stable until `out_valid && out_ready`; the block SHALL then clear `out_valid` and return to IDLE on the same edge.
REQ-030 `start` in the cycle DONE completes SHALL be ignored, because it is sampled outside IDLE.
REQ-031 The element counter SHALL be ADDR_WIDTH+1 bits so that len = MAX_LEN terminates without wrap.
REQ-032 `rd_addr` SHALL be 0 whenever `rd_en` = 0.
REQ-033 Total latency from `start` to `out_valid` SHALL be 1 + 1 + len + MAC_LATENCY + 1 cycles.

Reset
REQ-034 Asserting `reset_n` low at any time, including mid-ISSUE or mid-DONE, SHALL force IDLE immediately.
REQ-035 While in reset, all outputs SHALL be 0: `busy`, `err`, `rd_en`, `rd_addr`, `mac_valid`, `mac_clear`, `out_valid` and `out_data`.
REQ-036 A run aborted by reset SHALL NOT produce `out_valid`; the next run SHALL begin with CLEAR as normal.

Structure
REQ-037 Package mac_pkg SHALL hold the state enum type and the default width constants shared with MAC_Unit instances.
REQ-038 The block SHALL be a single module with no sub-module, instantiated beside the MAC and wired `mac_*` to its ports.

Verification
REQ-039 Scenario: len=4, A={1,2,3,4}, B={5,6,7,8}, bench MAC model with latency 2 -> `out_data` = 70 and `out_valid` exactly 9 cycles after `start`.
REQ-040 Scenario: len=0, then len=65 -> one `err` pulse each; `rd_en`, `mac_clear` and `busy` stay 0.
REQ-041 Scenario: `start` pulsed again during ISSUE of a len=3 run -> exactly 3 `rd_en` cycles and a single result.
REQ-042 Scenario: `out_ready` held low for 5 cycles in DONE -> `out_data` stable; `busy` drops the cycle after `out_ready` rises.
REQ-043 Scenario: `reset_n` low at the third `rd_en` of a len=8 run -> all outputs 0 and no `out_valid`; a following len=2 run, A={-3,4}, B={7,-2} -> `out_data` = -29.
REQ-044 Scenario: len=64, all A = -32768 and all B = -32768 -> addresses 0..63 issued in order, and `out_data` equals the MAC model's wrapped 32-bit sum.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared state encoding and default widths for the dot-product sequencer and the MAC units it drives.
package mac_pkg;

  localparam int MAC_DATA_WIDTH      = 16;
  localparam int MAC_ACC_WIDTH       = 32;
  localparam int MAC_MAX_LEN         = 64;
  localparam int MAC_LATENCY_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mac_dot_sequencer.sv
// Streams A/B operand pairs from memory into an external MAC, waits out its pipeline,
// then presents the accumulated dot product on a valid/ready output.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH  = MAC_DATA_WIDTH,
  parameter int ACC_WIDTH   = MAC_ACC_WIDTH,
  parameter int MAX_LEN     = MAC_MAX_LEN,
  parameter int MAC_LATENCY = MAC_LATENCY_DEFAULT,
  parameter int ADDR_WIDTH  = $clog2(MAX_LEN)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic        [ADDR_WIDTH:0]   len,
  output logic                         busy,
  output logic                         err,
  output logic                         rd_en,
  output logic        [ADDR_WIDTH-1:0] rd_addr,
  input  logic signed [DATA_WIDTH-1:0] a_data,
  input  logic signed [DATA_WIDTH-1:0] b_data,
  output logic signed [DATA_WIDTH-1:0] mac_multiplier,
  output logic signed [DATA_WIDTH-1:0] mac_multiplicand,
  output logic                         mac_valid,
  output logic                         mac_clear,
  input  logic signed [ACC_WIDTH-1:0]  mac_result,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int LEN_W   = ADDR_WIDTH + 1;
  localparam int DRAIN_W = $clog2(MAC_LATENCY + 1) + 1;

  seq_state_t         state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   elem_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               len_ok;

  assign len_ok = (len != '0) && (len <= LEN_W'(MAX_LEN));

  assign busy      = (state != ST_IDLE);
  assign mac_clear = (state == ST_CLEAR);
  assign rd_en     = (state == ST_ISSUE);
  assign rd_addr   = rd_en ? elem_cnt[ADDR_WIDTH-1:0] : '0;

  // Memory read data lines up with the registered mac_valid, so operands pass straight through.
  assign mac_multiplier   = a_data;
  assign mac_multiplicand = b_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      elem_cnt  <= '0;
      drain_cnt <= '0;
      err       <= 1'b0;
      mac_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      err       <= 1'b0;
      mac_valid <= rd_en;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q    <= len;
              elem_cnt <= '0;
              state    <= ST_CLEAR;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_CLEAR: state <= ST_ISSUE;
        ST_ISSUE: begin
          if (elem_cnt == len_q - LEN_W'(1)) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            elem_cnt <= elem_cnt + LEN_W'(1);
          end
        end
        // The first DRAIN cycle carries the final mac_valid; MAC_LATENCY more cycles let it settle.
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_W'(MAC_LATENCY)) begin
            out_data  <= mac_result;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioural operand memory and a 2-cycle MAC model.
module tb_mac_dot_sequencer;

  localparam int DW     = 16;
  localparam int AW     = 32;
  localparam int MAXL   = 64;
  localparam int ADDR_W = 6;
  localparam int LAT    = 2;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   start = 1'b0;
  logic [ADDR_W:0]        len = '0;
  logic                   out_ready = 1'b1;
  logic                   busy, err, rd_en, mac_valid, mac_clear, out_valid;
  logic [ADDR_W-1:0]      rd_addr;
  logic signed [DW-1:0]   a_data = '0;
  logic signed [DW-1:0]   b_data = '0;
  logic signed [DW-1:0]   mac_multiplier, mac_multiplicand;
  logic signed [AW-1:0]   mac_result = '0;
  logic signed [AW-1:0]   acc = '0;
  logic signed [AW-1:0]   prod_model;
  logic signed [AW-1:0]   out_data;
  logic signed [DW-1:0]   mem_a [MAXL];
  logic signed [DW-1:0]   mem_b [MAXL];

  int n_checks = 0;
  int n_fail   = 0;

  mac_dot_sequencer #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_LEN(MAXL), .MAC_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .busy(busy), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
    .mac_multiplier(mac_multiplier), .mac_multiplicand(mac_multiplicand),
    .mac_valid(mac_valid), .mac_clear(mac_clear), .mac_result(mac_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Synchronous operand memory: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end
  end

  // MAC model: accumulate on the edge after mac_valid, then one output register stage.
  assign prod_model = AW'(mac_multiplier) * AW'(mac_multiplicand);
  always @(posedge clk) begin
    if (mac_clear) acc <= '0;
    else if (mac_valid) acc <= acc + prod_model;
    mac_result <= acc;
  end

  task automatic fill_mem(input int n, input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
    int av[4];
    int bv[4];
    av = '{a0, a1, a2, a3};
    bv = '{b0, b1, b2, b3};
    for (int i = 0; i < MAXL; i++) begin
      mem_a[i] = (i < n) ? DW'(av[i]) : '0;
      mem_b[i] = (i < n) ? DW'(bv[i]) : '0;
    end
  endtask

  // Drives one start pulse (optionally a second one mid-run) and observes until out_valid or timeout.
  task automatic run_dot(input int l, input int restart_at, input int limit,
                         output int lat, output int rd_cnt, output int clr_cnt,
                         output int first_rd, output int last_rd, output int addr_bad,
                         output int err_cnt);
    lat = -1; rd_cnt = 0; clr_cnt = 0; first_rd = -1; last_rd = -1; addr_bad = 0; err_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    len   = (ADDR_W+1)'(l);
    for (int k = 1; k <= limit && lat < 0; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (k == restart_at) len = 7'd5;
      if (rd_en) begin
        if (int'(rd_addr) != rd_cnt) addr_bad++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
        rd_cnt++;
      end else if (rd_addr != '0) begin
        addr_bad++;
      end
      if (mac_clear) clr_cnt++;
      if (err) err_cnt++;
      if (out_valid) lat = k;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, err, rd_en, mac_valid, mac_clear, out_valid} !== 6'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000000", {busy, err, rd_en, mac_valid, mac_clear, out_valid});
    end
    n_checks++; if (rd_addr !== '0) begin n_fail++; $display("[TB] FAIL reset_addr: got %0d expected 0", rd_addr); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %0d expected 0", out_data); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_basic_dot;
    int lat, rdc, clr, fr, lr, bad, ec;
    out_ready = 1'b1;
    fill_mem(4, 1, 2, 3, 4, 5, 6, 7, 8);
    run_dot(4, 0, 40, lat, rdc, clr, fr, lr, bad, ec);
    n_checks++; if (lat !== 9) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d expected 9", lat); end
    n_checks++; if (out_data !== 32'sd70) begin n_fail++; $display("[TB] FAIL basic_data: got %0d expected 70", out_data); end
    n_checks++; if (rdc !== 4 || fr !== 2 || lr !== 5) begin
      n_fail++; $display("[TB] FAIL basic_rd: count %0d first %0d last %0d expected 4/2/5", rdc, fr, lr);
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL basic_addr: %0d bad addresses expected 0", bad); end
    n_checks++; if (clr !== 1) begin n_fail++; $display("[TB] FAIL basic_clear: got %0d clear cycles expected 1", clr); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_release: busy %b out_valid %b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_len_errors;
    int lens[2];
    lens = '{0, 65};
    for (int t = 0; t < 2; t++) begin
      int side_effects;
      side_effects = 0;
      @(negedge clk);
      start = 1'b1;
      len   = (ADDR_W+1)'(lens[t]);
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_pulse_len%0d: got %b expected 1", lens[t], err); end
      if (rd_en || mac_clear || busy) side_effects++;
      @(negedge clk);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_width_len%0d: got %b expected 0", lens[t], err); end
      for (int k = 0; k < 4; k++) begin
        if (rd_en || mac_clear || busy) side_effects++;
        @(negedge clk);
      end
      n_checks++; if (side_effects !== 0) begin
        n_fail++; $display("[TB] FAIL err_quiet_len%0d: got %0d active cycles expected 0", lens[t], side_effects);
      end
    end
  endtask

  task automatic test_start_during_issue;
    int lat, rdc, clr, fr, lr, bad, ec, extra;
    extra = 0;
    out_ready = 1'b1;
    fill_mem(3, 1, 2, 3, 0, 4, 5, 6, 0);
    run_dot(3, 3, 40, lat, rdc, clr, fr, lr, bad, ec);
    n_checks++; if (lat !== 8) begin n_fail++; $display("[TB] FAIL restart_latency: got %0d expected 8", lat); end
    n_checks++; if (out_data !== 32'sd32) begin n_fail++; $display("[TB] FAIL restart_data: got %0d expected 32", out_data); end
    n_checks++; if (rdc !== 3 || ec !== 0) begin
      n_fail++; $display("[TB] FAIL restart_rd: rd %0d err %0d expected 3 0", rdc, ec);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rd_en || out_valid || err || busy) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("[TB] FAIL restart_single: got %0d extra active cycles expected 0", extra); end
  endtask

  task automatic test_backpressure;
    int lat, rdc, clr, fr, lr, bad, ec, unstable;
    unstable = 0;
    out_ready = 1'b0;
    fill_mem(2, 2, 3, 0, 0, 4, 5, 0, 0);
    run_dot(2, 0, 40, lat, rdc, clr, fr, lr, bad, ec);
    n_checks++; if (lat !== 7) begin n_fail++; $display("[TB] FAIL bp_latency: got %0d expected 7", lat); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 32'sd23 || busy !== 1'b1) unstable++;
    end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", unstable); end
    out_ready = 1'b1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_busy_before: got %b expected 1", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_release: busy %b out_valid %b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_abort;
    int lat, rdc, clr, fr, lr, bad, ec, leaks;
    leaks = 0;
    out_ready = 1'b1;
    fill_mem(4, 9, 9, 9, 9, 9, 9, 9, 9);
    @(negedge clk);
    start = 1'b1;
    len   = 7'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rd_en !== 1'b1 || rd_addr !== 6'd2) begin
      n_fail++; $display("[TB] FAIL abort_third_rd: rd_en %b addr %0d expected 1 2", rd_en, rd_addr);
    end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({busy, err, rd_en, mac_valid, mac_clear, out_valid} !== 6'b0 || rd_addr !== '0 || out_data !== '0) begin
      n_fail++; $display("[TB] FAIL abort_outputs: flags %b addr %0d data %0d expected all 0",
                         {busy, err, rd_en, mac_valid, mac_clear, out_valid}, rd_addr, out_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid || rd_en || busy) leaks++;
    end
    n_checks++; if (leaks !== 0) begin n_fail++; $display("[TB] FAIL abort_no_result: got %0d active cycles expected 0", leaks); end
    fill_mem(2, -3, 4, 0, 0, 7, -2, 0, 0);
    run_dot(2, 0, 40, lat, rdc, clr, fr, lr, bad, ec);
    n_checks++; if (lat !== 7 || clr !== 1 || fr !== 2) begin
      n_fail++; $display("[TB] FAIL abort_rerun: latency %0d clears %0d first_rd %0d expected 7 1 2", lat, clr, fr);
    end
    n_checks++; if (out_data !== -32'sd29) begin n_fail++; $display("[TB] FAIL abort_rerun_data: got %0d expected -29", out_data); end
  endtask

  task automatic test_max_len;
    int lat, rdc, clr, fr, lr, bad, ec;
    out_ready = 1'b1;
    for (int i = 0; i < MAXL; i++) begin
      mem_a[i] = -16'sd32768;
      mem_b[i] = -16'sd32768;
    end
    run_dot(64, 0, 200, lat, rdc, clr, fr, lr, bad, ec);
    n_checks++; if (lat !== 69) begin n_fail++; $display("[TB] FAIL max_latency: got %0d expected 69", lat); end
    n_checks++; if (rdc !== 64 || fr !== 2 || lr !== 65 || bad !== 0) begin
      n_fail++; $display("[TB] FAIL max_rd: count %0d first %0d last %0d bad %0d expected 64 2 65 0", rdc, fr, lr, bad);
    end
    // 64 * 2^30 = 2^36, which wraps to 0 in 32 bits.
    n_checks++; if (out_data !== 32'sd0) begin n_fail++; $display("[TB] FAIL max_data: got %0d expected 0", out_data); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL max_release: busy %b expected 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < MAXL; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    test_reset();
    test_basic_dot();
    test_len_errors();
    test_start_during_issue();
    test_backpressure();
    test_reset_abort();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
